// File: rtl/freq_gate_counter.sv
// Gated edge counter for the frequency meter: counts Sig_In rising edges over GATE_CYCLES clocks,
// latches the count on Freq_Bin with a Do_Translate pulse, then waits for Conv_Done before re-arming.
module freq_gate_counter #(
  parameter int CLK_FREQ    = 50000000,
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 20
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic             Sig_In,
  input  logic             Conv_Done,
  output logic [CNT_W-1:0] Freq_Bin,
  output logic             Do_Translate,
  output logic             Overflow,
  output logic             Busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  generate
    if (GATE_CYCLES < 2 || CLK_FREQ < 1) begin : g_bad_param
      $error("freq_gate_counter: GATE_CYCLES must be >= 2 and CLK_FREQ positive");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_LATCH,
    S_WAIT_CONV
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic             r_s1, r_s2, r_s3;

  logic             w_edge;
  logic             w_cnt_max;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;

  assign w_edge    = r_s2 & ~r_s3;
  assign w_cnt_max = &r_edge_cnt;
  assign w_cnt_nxt = (w_edge && !w_cnt_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  // Flag means an edge was actually lost at full scale, not merely that full scale was reached.
  assign w_sat_nxt = r_sat | (w_edge & w_cnt_max);

  assign Busy = (r_state != S_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      Freq_Bin     <= '0;
      Do_Translate <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      r_s1         <= Sig_In;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      Do_Translate <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          r_gate_cnt <= '0;
          if (Enable) r_state <= S_GATE;
        end
        S_GATE: begin
          if (!Enable) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else if (r_gate_cnt == GATE_LAST) begin
            // Result is loaded on entry to LATCH so it is already valid while Do_Translate is high.
            r_state      <= S_LATCH;
            r_gate_cnt   <= '0;
            Freq_Bin     <= w_cnt_nxt;
            Overflow     <= w_sat_nxt;
            Do_Translate <= 1'b1;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_cnt_nxt;
            r_sat      <= w_sat_nxt;
          end
        end
        S_LATCH: begin
          r_state <= S_WAIT_CONV;
        end
        S_WAIT_CONV: begin
          if (Conv_Done) begin
            r_gate_cnt <= '0;
            r_state    <= Enable ? S_GATE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Upstream stage of the frequency meter. Measures an asynchronous input signal by counting its rising edges over a fixed gate window of clock cycles.
- At the end of each window it presents the 20-bit count on Freq_Bin and issues a one-cycle Do_Translate pulse to the binary-to-BCD converter.
- It does not start the next window until the converter returns Conv_Done, then repeats continuously while enabled.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; documentation only.
- GATE_CYCLES, 50000000, gate window length in Clk cycles (1 s at 50 MHz); must be >= 2. Tests use 100.
- CNT_W, 20, edge counter and Freq_Bin width; must match the converter input width.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  run continuous measurements when high.
- Sig_In  input  1  asynchronous signal under measurement.
- Conv_Done  input  1  one-cycle done pulse from the converter (its Done_Sig).
- Freq_Bin  output  CNT_W  latched edge count of the last completed window.
- Do_Translate  output  1  one-cycle start pulse to the converter.
- Overflow  output  1  last window saturated the counter.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: Rst_n is asynchronous, active-low; Clk is the clock. Reset forces state IDLE and clears all registers.
  - Freq_Bin=0, Do_Translate=0, Overflow=0, Busy=0.
  - Gate counter=0, edge counter=0, synchronizer flops=0.
- Synchronizer:
  - Sig_In passes through two flops (s1, s2), then one history flop s3.
  - edge = s2 & ~s3.
  - A Sig_In rising edge produces edge 3 Clk cycles later. Pulses narrower than one Clk period may be missed.
- State machine:
  - IDLE: edge counter cleared. If Enable=1, go to GATE next cycle with gate counter=0.
  - GATE: gate counter increments every cycle. An edge in any GATE cycle increments the edge counter. When gate counter = GATE_CYCLES-1, go to LATCH. The window is exactly GATE_CYCLES cycles, and an edge in its last cycle is counted.
  - LATCH, one cycle:
    - Freq_Bin <= edge counter; Overflow <= saturation flag.
    - Do_Translate=1 for this cycle only.
    - Edge counter and flag cleared; go to WAIT_CONV.
  - WAIT_CONV:
    - Ignore edges. Hold Freq_Bin.
    - On Conv_Done=1: go to GATE if Enable=1, else IDLE. Gate counter restarts at 0.
- Saturation: the edge counter stops at 2^CNT_W-1 (1048575) and sets the saturation flag. There is no wrap-around.
- Enable dropping:
  - In GATE: abort the window, go to IDLE. Freq_Bin and Overflow keep their previous values, and no Do_Translate is issued.
  - In LATCH or WAIT_CONV: the conversion completes normally, then the FSM goes to IDLE.
- Conv_Done timing: Conv_Done outside WAIT_CONV is ignored. A Conv_Done in the same cycle as LATCH is ignored. WAIT_CONV waits indefinitely for Conv_Done.
- Do_Translate is never asserted for two consecutive cycles. Its minimum spacing is GATE_CYCLES+2 cycles.
- Freq_Bin changes only in the LATCH cycle. It is stable while the converter samples it and throughout the conversion.
- Reset mid-operation: immediate return to reset values. No Do_Translate pulse is generated.

Test Plan:
- GATE_CYCLES=100, Clk 10 ns, Sig_In square wave period 40 ns, Conv_Done stubbed 20 cycles after Do_Translate -> Freq_Bin=25, Overflow=0, exactly one Do_Translate pulse per window. Second window also gives 25.
- Sig_In held at 0 -> Freq_Bin=0, Overflow=0, Do_Translate still pulses after 100 gate cycles.
- CNT_W=4, Sig_In period 20 ns (50 edges per window) -> Freq_Bin=15, Overflow=1. The next window with Sig_In period 200 ns -> Freq_Bin=5, Overflow=0.
- Enable deasserted at gate cycle 50 -> no Do_Translate, Freq_Bin keeps its prior value, Busy=0 within 1 cycle. Re-enable -> a full 100-cycle window follows.
- Conv_Done withheld 500 cycles -> FSM stays in WAIT_CONV, no new edges counted, no second Do_Translate. Conv_Done pulse -> GATE resumes the next cycle.
- Rst_n pulsed low mid-GATE and mid-WAIT_CONV -> all outputs 0 asynchronously. After release, a normal 100-cycle window gives the correct count.
